// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe
//   Single-stage RV32I decoder with a valid/ready output register and an
//   illegal-instruction trap handshake.
//
//   An accepted legal instruction produces its control word one cycle later.
//   That word is held until out_ready. An accepted illegal instruction loads
//   nothing. Instead it raises trap_req, enters TRAP, and bumps the saturating
//   illegal_cnt. TRAP blocks input until trap_ack. flush drops the held word
//   and any pending trap, and has priority over accept and trap_ack.
//
//   Ports
//     clk, rst_n                clock, async active-low reset
//     in_valid/in_ready, instr  instruction input handshake
//     flush                     discard held word and pending trap
//     out_valid/out_ready       control word output handshake
//     reg_write, mem_write, jump, branch, alu_src, result_src, imm_src,
//     alu_control, branch_cond  registered control word
//     trap_req/trap_ack         illegal-instruction trap handshake
//     illegal_cnt               saturating count of accepted illegal words
//
//   Build option: define DECODE_MULDIV_EN to decode the M-extension ops
//   (funct7 0000001) as alu_control 16..23. Without it they are illegal.
module decode_ctrl_pipe #(
  parameter int ALU_OP_W = 5,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                reg_write,
  output logic                mem_write,
  output logic                jump,
  output logic                branch,
  output logic                alu_src,
  output logic [1:0]          result_src,
  output logic [2:0]          imm_src,
  output logic [ALU_OP_W-1:0] alu_control,
  output logic [2:0]          branch_cond,
  output logic                trap_req,
  input  logic                trap_ack,
  output logic [CNT_W-1:0]    illegal_cnt
);

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(9);

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_e;

  typedef struct packed {
    logic                reg_write;
    logic                mem_write;
    logic                jump;
    logic                branch;
    logic                alu_src;
    logic [1:0]          result_src;
    logic [2:0]          imm_src;
    logic [ALU_OP_W-1:0] alu_control;
    logic [2:0]          branch_cond;
  } ctrl_t;

  state_e           state_q;
  logic             out_valid_q, trap_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, dec;
  logic             legal, accept;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register and immediate-low fields are not needed for control decode.
  logic unused_fields;
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // funct3 to ALU op for the base register/immediate ALU group
  function automatic logic [ALU_OP_W-1:0] alu_of(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_of = ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_SLT;
      3'b011:  alu_of = ALU_SLTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec   = '0;
    legal = 1'b0;
    case (opcode)
      7'b0110011: begin                        // R-type
        dec.reg_write = 1'b1;
        case (funct7)
          7'b0000000: begin
            legal           = 1'b1;
            dec.alu_control = alu_of(funct3);
          end
          7'b0100000: begin                    // only SUB and SRA use the alt encoding
            legal           = (funct3 == 3'b000) || (funct3 == 3'b101);
            dec.alu_control = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
          end
`ifdef DECODE_MULDIV_EN
          7'b0000001: begin
            legal           = 1'b1;
            dec.alu_control = ALU_OP_W'({2'b10, funct3});
          end
`endif
          default: legal = 1'b0;
        endcase
      end
      7'b0010011: begin                        // I-type ALU
        dec.reg_write   = 1'b1;
        dec.alu_src     = 1'b1;
        dec.alu_control = alu_of(funct3);
        legal           = 1'b1;
        if (funct3 == 3'b001) legal = (funct7 == 7'b0000000);
        if (funct3 == 3'b101) begin
          legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          if (funct7 == 7'b0100000) dec.alu_control = ALU_SRA;
        end
      end
      7'b0000011: begin                        // LW
        legal          = (funct3 == 3'b010);
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'd1;
      end
      7'b0100011: begin                        // SW
        legal         = (funct3 == 3'b010);
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = 3'd1;
      end
      7'b1100011: begin                        // branches compare via SUB/SLT/SLTU
        legal           = (funct3[2:1] != 2'b01);
        dec.branch      = 1'b1;
        dec.imm_src     = 3'd2;
        dec.branch_cond = funct3;
        dec.alu_control = !funct3[2] ? ALU_SUB : (!funct3[1] ? ALU_SLT : ALU_SLTU);
      end
      7'b0110111: begin                        // LUI
        legal         = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = 3'd3;
      end
      7'b0010111: begin                        // AUIPC: result taken from the PC adder
        legal          = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.imm_src    = 3'd3;
        dec.result_src = 2'd2;
      end
      7'b1101111: begin                        // JAL
        legal          = 1'b1;
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 2'd2;
        dec.imm_src    = 3'd4;
      end
      7'b1100111: begin                        // JALR
        legal          = (funct3 == 3'b000);
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'd2;
      end
      default: legal = 1'b0;
    endcase
  end

  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      trap_q      <= 1'b0;
      cnt_q       <= '0;
      ctrl_q      <= '0;
    end else if (flush) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (state_q == TRAP && trap_ack) begin
        state_q <= RUN;
        trap_q  <= 1'b0;
      end
      // accept implies RUN, so it never collides with the trap_ack branch
      if (accept) begin
        if (legal) begin
          out_valid_q <= 1'b1;
          ctrl_q      <= dec;
        end else begin
          state_q <= TRAP;
          trap_q  <= 1'b1;
          cnt_q   <= cnt_d;
        end
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign trap_req    = trap_q;
  assign illegal_cnt = cnt_q;
  assign reg_write   = ctrl_q.reg_write;
  assign mem_write   = ctrl_q.mem_write;
  assign jump        = ctrl_q.jump;
  assign branch      = ctrl_q.branch;
  assign alu_src     = ctrl_q.alu_src;
  assign result_src  = ctrl_q.result_src;
  assign imm_src     = ctrl_q.imm_src;
  assign alu_control = ctrl_q.alu_control;
  assign branch_cond = ctrl_q.branch_cond;

endmodule

// File: doc/decode_ctrl_pipe.md
DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

Interface
REQ-001 Parameter ALU_OP_W, default 5: ALU control code width; SHALL be >=5.
REQ-002 Parameter CNT_W, default 8: illegal-instruction counter width.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  instr valid; in_ready  out  1  block can accept.
REQ-006 instr  in  32  RV32 instruction word.
REQ-007 flush  in  1  discard held output and pending trap.
REQ-008 out_valid  out  1  control word valid; out_ready  in  1  downstream accepts.
REQ-009 reg_write, mem_write, jump, branch, alu_src  out  1 each  registered control bits.
REQ-010 result_src  out  2  (0 ALU, 1 mem, 2 PC); imm_src  out  3  (0 I, 1 S, 2 B, 3 U, 4 J).
REQ-011 alu_control  out  ALU_OP_W  ALU op; branch_cond  out  3  registered funct3 of branches.
REQ-012 trap_req  out  1  illegal instruction pending; trap_ack  in  1  trap taken.
REQ-013 illegal_cnt  out  CNT_W  count of accepted illegal instructions.

Function
REQ-014 ALU codes SHALL be: ADD 0, SUB 1, AND 2, OR 3, SLL 4, SRL 5, XOR 6, SRA 7, SLT 8, SLTU 9.
REQ-015 Decode SHALL cover R-type (opcode 0110011: the 10 ops above), I-ALU (0010011: ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI), LW, SW, BEQ/BNE/BLT/BGE/BLTU/BGEU, LUI, AUIPC, JAL, JALR.
REQ-016 Control values: LW result_src 1, alu_src 1; SW mem_write 1, imm_src 1; branches branch 1, imm_src 2, reg_write 0; AUIPC/JAL/JALR result_src 2; JAL/JALR jump 1; LUI imm_src 3, alu_src 1.
REQ-017 Branch alu_control SHALL be SUB for funct3 000/001, SLT for 100/101, SLTU for 110/111.
REQ-018 Illegal: unknown opcode; branch funct3 010/011; LW/SW funct3 != 010; JALR funct3 != 000; R-type funct7 not in {0000000, 0100000 for SUB/SRA}; SLLI/SRLI/SRAI bad imm[11:5].
REQ-019 States SHALL be RUN and TRAP; reset state RUN.
REQ-020 in_ready = (state==RUN) && (!out_valid || out_ready) && !flush.
REQ-021 Accepted legal instruction SHALL appear on outputs with out_valid=1 exactly one cycle later; throughput one per cycle.
REQ-022 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-023 Accepted illegal instruction: no output load (out_valid clears if current word popped), state -> TRAP, trap_req=1 next cycle, illegal_cnt +1 saturating at all-ones.
REQ-024 In TRAP: in_ready=0, trap_req=1 until trap_ack; trap_ack -> RUN next cycle; trap_ack in RUN ignored.
REQ-025 flush SHALL clear out_valid and trap_req and force RUN next cycle; it beats a same-cycle accept or trap_ack; illegal_cnt unaffected.
REQ-026 A held valid word SHALL drain normally when the trap occurs behind it.

Reset
REQ-027 rst_n low SHALL asynchronously force: state RUN, out_valid 0, trap_req 0, illegal_cnt 0, all control outputs 0 (alu_control ADD, result_src ALU, imm_src I, branch_cond 0).
REQ-028 Reset mid-transfer SHALL drop the held word; no trap survives reset.

Configuration
REQ-029 Macro DECODE_MULDIV_EN: defined -> R-type funct7 0000001 decodes MUL..REMU (funct3 000..111) to alu_control 16..23, reg_write 1.
REQ-030 Without DECODE_MULDIV_EN, funct7 0000001 R-type SHALL be illegal per REQ-023.

Verification
REQ-031 Reset, then ADD x1,x2,x3 (0x003100B3) valid -> next cycle out_valid=1, reg_write=1, alu_control=0, alu_src=0.
REQ-032 BLTU (funct3 110) with out_ready=0 for 3 cycles -> branch=1, alu_control=9, branch_cond=110 held constant; in_ready=0 throughout.
REQ-033 Opcode 0x7F accepted -> trap_req=1, illegal_cnt=1, in_ready=0; trap_ack one cycle -> RUN, in_ready=1.
REQ-034 256 illegal words with acks (CNT_W=8) -> illegal_cnt stays 255.
REQ-035 flush with in_valid and pending word -> out_valid=0 next cycle, instr not loaded, trap cleared.
REQ-036 MUL (funct7 0000001, funct3 000): with DECODE_MULDIV_EN -> alu_control=16; without -> trap_req=1.
